// File: rtl/pdm_ddr_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// pdm_ddr_capture_ctrl_if
// Output word handshake between the PDM capture controller and the mic
// decimation filters.
//   data_left  [WORD_WIDTH] left-channel word, MSB = oldest bit
//   data_right [WORD_WIDTH] right-channel word, MSB = oldest bit
//   data_valid              word pair valid (producer)
//   data_ready              consumer accepts word pair (consumer)
// Modports: master = capture controller, slave = consumer.
// ---------------------------------------------------------------------------
interface pdm_ddr_capture_ctrl_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] data_left;
    logic [WORD_WIDTH-1:0] data_right;
    logic                  data_valid;
    logic                  data_ready;

    modport master (
        output data_left,
        output data_right,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_left,
        input  data_right,
        input  data_valid,
        output data_ready
    );
endinterface

// File: rtl/pdm_ddr_capture_ctrl.sv
// ---------------------------------------------------------------------------
// pdm_ddr_capture_ctrl
// Sequences a DDR input register pair for a shared-line PDM microphone pair.
// Generates the PDM clock and the capture-flop clock enable, shifts the
// rising-edge bit (q0, left) and falling-edge bit (q1, right) into per-channel
// shift registers, discards WARMUP_WORDS words after each start, and then
// presents left/right word pairs over a valid/ready handshake.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous, active-low reset
//   enable   in   run request (level)
//   q0       in   rising-edge captured bit (left)
//   q1       in   falling-edge captured bit (right)
//   pdm_clk  out  registered PDM clock to the microphones
//   iddr_ce  out  clock enable to the DDR capture flops
//   overrun  out  sticky: a word completed while the previous pair was pending
//   out_if   master side of the word-pair handshake
// ---------------------------------------------------------------------------
module pdm_ddr_capture_ctrl #(
    parameter int CLK_DIV      = 16,
    parameter int WORD_WIDTH   = 8,
    parameter int WARMUP_WORDS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          q0,
    input  logic                          q1,
    output logic                          pdm_clk,
    output logic                          iddr_ce,
    output logic                          overrun,
    pdm_ddr_capture_ctrl_if.master        out_if
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(WORD_WIDTH + 1);
    localparam int WARM_W = (WARMUP_WORDS > 0) ? $clog2(WARMUP_WORDS + 1) : 1;

    localparam logic [DIV_W-1:0]  DIV_LEFT  = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_WIDTH - 1);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_WORDS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WARMUP = 2'd1;
    localparam logic [1:0] S_RUN    = 2'd2;

    logic [1:0]            state_reg,     state_next;
    logic [DIV_W-1:0]      div_reg,       div_next;
    logic                  pdm_clk_reg,   pdm_clk_next;
    logic [WORD_WIDTH-1:0] left_sr_reg,   left_sr_next;
    logic [WORD_WIDTH-1:0] right_sr_reg,  right_sr_next;
    logic [BIT_W-1:0]      bit_cnt_reg,   bit_cnt_next;
    logic [WARM_W-1:0]     warm_cnt_reg,  warm_cnt_next;
    logic [WORD_WIDTH-1:0] out_left_reg,  out_left_next;
    logic [WORD_WIDTH-1:0] out_right_reg, out_right_next;
    logic                  valid_reg,     valid_next;
    logic                  overrun_reg,   overrun_next;

    logic                  active;
    logic                  left_strobe;
    logic                  right_strobe;
    logic                  word_done;
    logic                  xfer;
    logic                  load;
    logic [WORD_WIDTH-1:0] right_word;

    assign active       = (state_reg != S_IDLE);
    // Strobes are gated by enable so that a disable cycle never commits a
    // bit or a word: the partial word is thrown away as the block idles.
    assign left_strobe  = active && enable && (div_reg == DIV_LEFT);
    assign right_strobe = active && enable && (div_reg == DIV_LAST);
    assign word_done    = right_strobe && (bit_cnt_reg == BIT_LAST);
    assign xfer         = valid_reg && out_if.data_ready;
    // The right word is complete only after the current q1 bit is appended;
    // the left register already holds all bits by the completing strobe.
    assign right_word   = {right_sr_reg[WORD_WIDTH-2:0], q1};

    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        pdm_clk_next   = pdm_clk_reg;
        left_sr_next   = left_sr_reg;
        right_sr_next  = right_sr_reg;
        bit_cnt_next   = bit_cnt_reg;
        warm_cnt_next  = warm_cnt_reg;
        out_left_next  = out_left_reg;
        out_right_next = out_right_reg;
        valid_next     = valid_reg;
        overrun_next   = overrun_reg;
        load           = 1'b0;

        if (!enable) begin
            state_next    = S_IDLE;
            div_next      = '0;
            pdm_clk_next  = 1'b0;
            left_sr_next  = '0;
            right_sr_next = '0;
            bit_cnt_next  = '0;
            warm_cnt_next = '0;
        end else if (!active) begin
            // Start: PDM clock goes high together with the state change.
            state_next    = (WARMUP_WORDS == 0) ? S_RUN : S_WARMUP;
            div_next      = '0;
            pdm_clk_next  = 1'b1;
            left_sr_next  = '0;
            right_sr_next = '0;
            bit_cnt_next  = '0;
            warm_cnt_next = '0;
            overrun_next  = 1'b0;
        end else begin
            div_next     = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
            // Registered PDM clock follows the divider value it will sit at.
            pdm_clk_next = (div_next < DIV_HALF);

            if (left_strobe) begin
                left_sr_next = {left_sr_reg[WORD_WIDTH-2:0], q0};
            end

            if (right_strobe) begin
                right_sr_next = right_word;
                bit_cnt_next  = word_done ? '0 : bit_cnt_reg + 1'b1;
            end

            if (word_done && (state_reg == S_WARMUP)) begin
                if (warm_cnt_reg == WARM_LAST) begin
                    state_next    = S_RUN;
                    warm_cnt_next = '0;
                end else begin
                    warm_cnt_next = warm_cnt_reg + 1'b1;
                end
            end

            load = word_done && (state_reg == S_RUN);
        end

        // Output holding registers run independently of the capture state so
        // a pending pair survives a disable until it is accepted.
        if (load && (!valid_reg || xfer)) begin
            out_left_next  = left_sr_reg;
            out_right_next = right_word;
            valid_next     = 1'b1;
        end else begin
            if (load) begin
                overrun_next = 1'b1;
            end
            if (xfer) begin
                valid_next = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            div_reg       <= '0;
            pdm_clk_reg   <= 1'b0;
            left_sr_reg   <= '0;
            right_sr_reg  <= '0;
            bit_cnt_reg   <= '0;
            warm_cnt_reg  <= '0;
            out_left_reg  <= '0;
            out_right_reg <= '0;
            valid_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            pdm_clk_reg   <= pdm_clk_next;
            left_sr_reg   <= left_sr_next;
            right_sr_reg  <= right_sr_next;
            bit_cnt_reg   <= bit_cnt_next;
            warm_cnt_reg  <= warm_cnt_next;
            out_left_reg  <= out_left_next;
            out_right_reg <= out_right_next;
            valid_reg     <= valid_next;
            overrun_reg   <= overrun_next;
        end
    end

    assign pdm_clk           = pdm_clk_reg;
    assign iddr_ce           = active;
    assign overrun           = overrun_reg;
    assign out_if.data_left  = out_left_reg;
    assign out_if.data_right = out_right_reg;
    assign out_if.data_valid = valid_reg;

endmodule

// File: tb/tb_pdm_ddr_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pdm_ddr_capture_ctrl
// Scoreboard bench: the stimulus process keeps a bit-level reference model
// (bit queues per channel, word index, pending/overrun flags) and pushes each
// expected word pair into a queue; a negedge monitor compares the DUT against
// the model and pops expected pairs on each transfer.
// ---------------------------------------------------------------------------
module tb_pdm_ddr_capture_ctrl;

    localparam int CD = 4;
    localparam int WW = 8;
    localparam int WU = 2;
    localparam int WP = WW * CD;

    typedef struct packed {
        logic [WW-1:0] l;
        logic [WW-1:0] r;
    } pair_t;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic q0;
    logic q1;
    logic pdm_clk;
    logic iddr_ce;
    logic overrun;

    pdm_ddr_capture_ctrl_if #(.WORD_WIDTH(WW)) dif ();

    pdm_ddr_capture_ctrl #(
        .CLK_DIV      (CD),
        .WORD_WIDTH   (WW),
        .WARMUP_WORDS (WU)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .q0      (q0),
        .q1      (q1),
        .pdm_clk (pdm_clk),
        .iddr_ce (iddr_ce),
        .overrun (overrun),
        .out_if  (dif)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit    m_active;
    bit    m_valid;
    bit    m_overrun;
    int    m_ph;
    int    m_words;
    int    m_bitk;
    bit    use_pattern;
    bit    bits_l[$];
    bit    bits_r[$];
    pair_t exp_q[$];

    int n_vec;
    int n_err;

    logic [7:0] pat_l;
    logic [7:0] pat_r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply the effect of the clock edge that just happened, using the input
    // values that were presented to it.
    task automatic model_edge();
        bit    xfer;
        bit    done;
        pair_t np;
        if (!reset) return;
        xfer = m_valid && dif.data_ready;
        done = 1'b0;
        np   = '0;
        if (m_active && !enable) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_ph++;
            if (m_ph % WP == 0) begin
                for (int i = 0; i < WW; i++) begin
                    np.l = {np.l[WW-2:0], (bits_l.size() > 0) ? bits_l.pop_front() : 1'b0};
                    np.r = {np.r[WW-2:0], (bits_r.size() > 0) ? bits_r.pop_front() : 1'b0};
                end
                m_words++;
                if (m_words > WU) done = 1'b1;
            end
        end else if (enable) begin
            m_active  = 1'b1;
            m_ph      = 0;
            m_words   = 0;
            m_overrun = 1'b0;
            bits_l.delete();
            bits_r.delete();
        end
        if (done && (!m_valid || xfer)) begin
            exp_q.push_back(np);
            m_valid = 1'b1;
        end else begin
            if (done) m_overrun = 1'b1;
            if (xfer) m_valid = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_valid   = 1'b0;
        m_overrun = 1'b0;
        m_ph      = 0;
        m_words   = 0;
        exp_q.delete();
        bits_l.delete();
        bits_r.delete();
    endtask

    // One clock: account for the edge, then drive inputs for the next edge.
    task automatic cycle(input bit en, input bit rdy);
        bit b0;
        bit b1;
        @(posedge clk);
        model_edge();
        #1;
        enable = en;
        dif.data_ready = rdy;
        if (m_active && en && (m_ph % CD == 0)) begin
            if (use_pattern) begin
                b0 = pat_l[7 - (m_bitk % 8)];
                b1 = pat_r[7 - (m_bitk % 8)];
            end else begin
                b0 = 1'($urandom_range(0, 1));
                b1 = 1'($urandom_range(0, 1));
            end
            q0 = b0;
            q1 = b1;
            bits_l.push_back(b0);
            bits_r.push_back(b1);
            m_bitk++;
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        chk("data_valid", {31'd0, dif.data_valid}, {31'd0, m_valid});
        chk("overrun", {31'd0, overrun}, {31'd0, m_overrun});
        chk("iddr_ce", {31'd0, iddr_ce}, {31'd0, m_active});
        chk("pdm_clk", {31'd0, pdm_clk},
            {31'd0, (m_active && ((m_ph % CD) < CD / 2))});
        if (dif.data_valid) begin
            if (exp_q.size() == 0) begin
                chk("pair_expected", 32'd0, 32'd1);
            end else begin
                chk("data_left", {24'd0, dif.data_left}, {24'd0, exp_q[0].l});
                chk("data_right", {24'd0, dif.data_right}, {24'd0, exp_q[0].r});
                if (dif.data_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        n_vec = 0;
        n_err = 0;
        pat_l = 8'hA5;
        pat_r = 8'h3C;
        use_pattern = 1'b0;
        m_bitk = 0;
        model_reset();
        reset = 1'b0;
        enable = 1'b0;
        q0 = 1'b0;
        q1 = 1'b0;
        dif.data_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_data_left", {24'd0, dif.data_left}, 32'd0);
        chk("rst_data_right", {24'd0, dif.data_right}, 32'd0);
        chk("rst_valid", {31'd0, dif.data_valid}, 32'd0);

        // Idle with enable low
        repeat (100) cycle(1'b0, 1'b1);

        // Fixed pattern, first valid latency after warmup
        use_pattern = 1'b1;
        m_bitk = 0;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        t = 0;
        while (!dif.data_valid && t < 300) begin
            cycle(1'b1, 1'b1);
            t++;
        end
        chk("first_valid_latency", t, (WU + 1) * WP);
        chk("first_left", {24'd0, dif.data_left}, 32'h000000A5);
        chk("first_right", {24'd0, dif.data_right}, 32'h0000003C);
        repeat (3 * WP) cycle(1'b1, 1'b1);

        // Random data, mostly-ready consumer
        use_pattern = 1'b0;
        repeat (4 * WP) cycle(1'b1, $urandom_range(0, 3) != 0);

        // Backpressure across several completions
        repeat (3 * WP) cycle(1'b1, 1'b0);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        repeat (2 * WP) cycle(1'b1, 1'b1);

        // Disable after three bits of a word
        t = 0;
        while ((m_ph % WP) != 3 * CD && t < 2 * WP) begin
            cycle(1'b1, 1'b1);
            t++;
        end
        chk("overrun_before_disable", {31'd0, overrun}, 32'd1);
        repeat (10) cycle(1'b0, 1'b0);
        chk("idle_pdm_clk", {31'd0, pdm_clk}, 32'd0);
        chk("idle_iddr_ce", {31'd0, iddr_ce}, 32'd0);
        repeat (5) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        chk("overrun_cleared", {31'd0, overrun}, 32'd0);
        repeat (4 * WP) cycle(1'b1, $urandom_range(0, 7) != 0);

        // Asynchronous reset mid-word with a pair pending
        t = 0;
        while (!dif.data_valid && t < 2 * WP) begin
            cycle(1'b1, 1'b0);
            t++;
        end
        repeat (5) cycle(1'b1, 1'b0);
        @(posedge clk);
        model_edge();
        #3 reset = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", {31'd0, dif.data_valid}, 32'd0);
        chk("arst_left", {24'd0, dif.data_left}, 32'd0);
        chk("arst_right", {24'd0, dif.data_right}, 32'd0);
        chk("arst_pdm_clk", {31'd0, pdm_clk}, 32'd0);
        chk("arst_iddr_ce", {31'd0, iddr_ce}, 32'd0);
        chk("arst_overrun", {31'd0, overrun}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            model_edge();
        end
        #1;
        enable = 1'b0;
        dif.data_ready = 1'b1;
        reset = 1'b1;
        repeat (10) cycle(1'b0, 1'b1);
        repeat (4 * WP) cycle(1'b1, 1'b1);
        repeat (5) cycle(1'b0, 1'b1);

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pdm_ddr_capture_ctrl.md
# pdm_ddr_capture_ctrl

Controller that sequences a DDR input register pair for a shared-line PDM microphone pair: one mic drives data on the rising half of the PDM clock, the other on the falling half. The block generates the PDM clock and the capture enables, collects the rising-edge bit (`q0`) and falling-edge bit (`q1`) into per-channel shift registers, and emits parallel left/right words over a valid/ready handshake. It sits between the DDR capture flops and the mic decimation filters.

## Interface
- `CLK_DIV`, 16: system clocks per PDM clock period; even, >= 4.
- `WORD_WIDTH`, 8: bits per channel per output word; 2..32.
- `WARMUP_WORDS`, 2: completed words discarded after each start.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  run request; level-sensitive.
- `q0`  in  1  rising-edge captured bit (left channel).
- `q1`  in  1  falling-edge captured bit (right channel).
- `pdm_clk`  out  1  PDM clock to the microphones, registered.
- `iddr_ce`  out  1  clock enable to the DDR capture flops.
- `data_left`  out  WORD_WIDTH  left word, MSB = oldest bit.
- `data_right`  out  WORD_WIDTH  right word, MSB = oldest bit.
- `data_valid`  out  1  output word pair valid.
- `data_ready`  in  1  consumer accepts word pair.
- `overrun`  out  1  sticky: a word completed while the previous one was still pending.

## Operation
- States: IDLE, WARMUP, RUN.
- IDLE: divider counter `div` = 0, `pdm_clk` = 0, `iddr_ce` = 0, shift registers and bit counter cleared. `enable` = 1 -> WARMUP.
- WARMUP and RUN: `div` counts 0..CLK_DIV-1 and wraps. `pdm_clk` = 1 while `div` < CLK_DIV/2, else 0. `iddr_ce` = 1 in both states.
- Left strobe at `div` == CLK_DIV/2-1: shift `q0` into the left shift register (shift left, new bit at LSB).
- Right strobe at `div` == CLK_DIV-1: shift `q1` into the right shift register and increment the bit counter.
- Word complete: the right strobe that brings the bit counter to WORD_WIDTH. The bit counter resets to 0.
- In WARMUP, a completed word increments the warmup counter and is discarded. On reaching WARMUP_WORDS, the state goes to RUN. If WARMUP_WORDS = 0, the state enters RUN directly from IDLE.
- In RUN, a completed word goes to the output holding registers:
  - `data_valid` = 0, or `data_valid` & `data_ready` in the same cycle: load the new pair, `data_valid` = 1.
  - `data_valid` & !`data_ready`: drop the new pair, keep the old pair, set `overrun`.
- Handshake: a transfer occurs on a cycle with `data_valid` & `data_ready`. Without a new load, `data_valid` falls the next cycle. `data_left` and `data_right` stay stable while `data_valid` = 1.
- `enable` = 0 in any state -> IDLE next cycle:
  - Any partial word is discarded.
  - A pending output pair and `data_valid` are kept until accepted.
  - `overrun` is kept.
- `overrun` clears only on reset, or on the IDLE->WARMUP transition.

## Timing
- Reset values: `pdm_clk` 0, `iddr_ce` 0, `data_left` 0, `data_right` 0, `data_valid` 0, `overrun` 0, state IDLE, all counters 0.
- `enable` rising at cycle N: state is WARMUP at N+1 and `div` = 0 at N+1. `pdm_clk` = 1 and `iddr_ce` = 1 from N+1.
- Word period is WORD_WIDTH*CLK_DIV cycles.
- The first valid pair appears (WARMUP_WORDS+1)*WORD_WIDTH*CLK_DIV cycles after entering WARMUP: `data_valid` rises the cycle after the completing right strobe.
- Consumer throughput requirement: accept each pair within WORD_WIDTH*CLK_DIV cycles of `data_valid` rising, otherwise `overrun` is set.
- Reset asserted mid-word: all outputs take their reset values immediately (asynchronous). After release, operation restarts from IDLE.

## Test plan
- Reset/idle: `reset` low, then high with `enable` = 0 for 100 cycles -> all outputs 0, `pdm_clk` static 0.
- Basic capture: CLK_DIV=4, WORD_WIDTH=8, WARMUP_WORDS=0, `q0` driven as pattern 0xA5 and `q1` as 0x3C MSB-first, `data_ready` = 1 -> `data_valid` at cycle 33 after `enable`, `data_left`=0xA5, `data_right`=0x3C; `pdm_clk` period 4 with 50% duty.
- Warmup: WARMUP_WORDS=2, same stimulus -> first `data_valid` 96 cycles after entering WARMUP; first two words never presented.
- Backpressure/overrun: `data_ready` = 0 across two word completions -> first pair held unchanged, `overrun` = 1. Then `data_ready` = 1 on the cycle of the third completion -> old pair transferred, new pair loaded, `data_valid` stays 1.
- Disable mid-word: `enable` drops after 3 bits -> IDLE next cycle, `pdm_clk` = 0, `iddr_ce` = 0. Re-enable -> the next word contains only new bits and `overrun` is cleared.
- Async reset mid-run: assert `reset` between clock edges -> outputs reach reset values before the next `clk` edge.
